// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the CPU control sequencer: state encodings,
// instruction class opcodes and the special-class extended opcodes.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_RTYPE   = 4'b0000;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_SHIFT   = 4'b1000;
  localparam logic [3:0] OP_BCOND   = 4'b1100;
  localparam logic [3:0] OP_LUI     = 4'b1111;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  // One-hot instruction class; jump covers both JCOND and bcond.
  typedef struct packed {
    logic rtype;
    logic imm;
    logic shift;
    logic lui;
    logic load;
    logic stor;
    logic jal;
    logic jump;
    logic nop;
  } instr_class_t;

endpackage

// File: rtl/cpu_sequencer_class_decode.sv
// Combinational instruction classifier: maps the primary and extended
// opcodes onto exactly one instruction class.
module instr_class_decode
  import cpu_sequencer_pkg::*;
#(
  parameter int OP_BITS = 4
) (
  input  logic [OP_BITS-1:0] op_code,
  input  logic [OP_BITS-1:0] ext_op_code,
  output instr_class_t       cls
);

  always_comb begin
    cls = '0;
    if (op_code == OP_BITS'(OP_RTYPE)) begin
      cls.rtype = 1'b1;
    end else if (op_code == OP_BITS'(OP_SPECIAL)) begin
      // Unrecognised special extended codes fall through as NOPs
      if (ext_op_code == OP_BITS'(EXT_LOAD))
        cls.load = 1'b1;
      else if (ext_op_code == OP_BITS'(EXT_STOR))
        cls.stor = 1'b1;
      else if (ext_op_code == OP_BITS'(EXT_JAL))
        cls.jal = 1'b1;
      else if (ext_op_code == OP_BITS'(EXT_JCOND))
        cls.jump = 1'b1;
      else
        cls.nop = 1'b1;
    end else if (op_code == OP_BITS'(OP_SHIFT)) begin
      cls.shift = 1'b1;
    end else if (op_code == OP_BITS'(OP_BCOND)) begin
      cls.jump = 1'b1;
    end else if (op_code == OP_BITS'(OP_LUI)) begin
      cls.lui = 1'b1;
    end else begin
      cls.imm = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT FSM
// producing the datapath strobes and memory handshake.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int OP_BITS    = 4,
  parameter int STATE_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OP_BITS-1:0]    op_code,
  input  logic [OP_BITS-1:0]    ext_op_code,
  input  logic                  cond_true,
  input  logic                  mem_ready,
  input  logic                  halt_req,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic                  reg_write,
  output logic                  psr_write,
  output logic                  halted,
  output logic [STATE_BITS-1:0] state
);

  state_e       state_q;
  state_e       state_d;
  state_e       fetch_next;
  instr_class_t cls;

  logic mem_read_c, mem_write_c, ir_write_c, pc_inc_c;
  logic pc_load_c, reg_write_c, psr_write_c, halted_c;

  instr_class_decode #(.OP_BITS(OP_BITS)) u_class_decode (
    .op_code     (op_code),
    .ext_op_code (ext_op_code),
    .cls         (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= ST_FETCH;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d     = ST_FETCH;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_inc_c    = 1'b0;
    pc_load_c   = 1'b0;
    reg_write_c = 1'b0;
    psr_write_c = 1'b0;
    halted_c    = 1'b0;
    // halt_req only matters on the edge that would start a new fetch
    fetch_next  = halt_req ? ST_HALT : ST_FETCH;

    case (state_q)
      ST_FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_inc_c   = 1'b1;
          state_d    = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (cls.load || cls.stor) begin
          state_d = ST_MEM;
        end else if (cls.jump) begin
          pc_load_c = cond_true;
          state_d   = fetch_next;
        end else if (cls.nop) begin
          state_d = fetch_next;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_read_c  = cls.load;
        mem_write_c = cls.stor;
        if (!(cls.load || cls.stor))
          state_d = fetch_next;
        else if (!mem_ready)
          state_d = ST_MEM;
        else if (cls.load)
          state_d = ST_WB;
        else
          state_d = fetch_next;
      end
      ST_WB: begin
        reg_write_c = cls.rtype | cls.imm | cls.shift | cls.lui | cls.load | cls.jal;
        psr_write_c = cls.rtype | cls.imm;
        pc_load_c   = cls.jal;
        state_d     = fetch_next;
      end
      ST_HALT: begin
        halted_c = 1'b1;
        state_d  = halt_req ? ST_HALT : ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset silences every output immediately, not just from the next edge
  assign mem_read  = mem_read_c  & ~reset;
  assign mem_write = mem_write_c & ~reset;
  assign ir_write  = ir_write_c  & ~reset;
  assign pc_inc    = pc_inc_c    & ~reset;
  assign pc_load   = pc_load_c   & ~reset;
  assign reg_write = reg_write_c & ~reset;
  assign psr_write = psr_write_c & ~reset;
  assign halted    = halted_c    & ~reset;
  assign state     = STATE_BITS'(state_q);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed and random instructions are
// expanded into per-cycle expected outputs that a monitor pops and compares.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam int K_ALU    = 0;  // R-type / immediate: reg + psr write
  localparam int K_WB     = 1;  // shift / lui: reg write only
  localparam int K_LOAD   = 2;
  localparam int K_STOR   = 3;
  localparam int K_JAL    = 4;
  localparam int K_BRANCH = 5;
  localparam int K_NOP    = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] op_code = '0;
  logic [3:0] ext_op_code = '0;
  logic       cond_true = 1'b0;
  logic       mem_ready = 1'b0;
  logic       halt_req = 1'b0;
  logic       mem_read, mem_write, ir_write, pc_inc, pc_load;
  logic       reg_write, psr_write, halted;
  logic [2:0] state;
  logic [10:0] actual;

  logic [10:0] exp_q[$];
  int          tag_q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          instr_no = 0;
  bit          running = 1'b0;

  cpu_sequencer #(.OP_BITS(4), .STATE_BITS(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .op_code     (op_code),
    .ext_op_code (ext_op_code),
    .cond_true   (cond_true),
    .mem_ready   (mem_ready),
    .halt_req    (halt_req),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .reg_write   (reg_write),
    .psr_write   (psr_write),
    .halted      (halted),
    .state       (state)
  );

  always #5 clk = ~clk;

  assign actual = {state, halted, mem_read, mem_write, ir_write, pc_inc,
                   pc_load, reg_write, psr_write};

  function automatic logic [10:0] mk(input logic [2:0] st, input logic hl, mr, mw,
                                     ir, pci, pcl, rw, pw);
    return {st, hl, mr, mw, ir, pci, pcl, rw, pw};
  endfunction

  // Instruction behaviour classes taken straight from the opcode table
  function automatic int classify(input logic [3:0] op, input logic [3:0] ext);
    if (op == 4'b0000) return K_ALU;
    if (op == 4'b0100) begin
      if (ext == 4'b0000) return K_LOAD;
      if (ext == 4'b0100) return K_STOR;
      if (ext == 4'b1000) return K_JAL;
      if (ext == 4'b1100) return K_BRANCH;
      return K_NOP;
    end
    if (op == 4'b1000 || op == 4'b1111) return K_WB;
    if (op == 4'b1100) return K_BRANCH;
    return K_ALU;
  endfunction

  task automatic apply_stimulus(input bit rst, rdy, hreq, cond,
                                input logic [3:0] op, ext, input logic [10:0] exp);
    @(posedge clk);
    #1;
    reset       = rst;
    mem_ready   = rdy;
    halt_req    = hreq;
    cond_true   = cond;
    op_code     = op;
    ext_op_code = ext;
    exp_q.push_back(exp);
    tag_q.push_back(instr_no);
  endtask

  task automatic check_output(input string name, input logic [10:0] act,
                              input logic [10:0] exp, input int tag);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s instr=%0d got=%b want=%b (state,halted,mr,mw,ir,pci,pcl,rw,pw)",
               name, tag, act, exp);
    end
  endtask

  // Monitor: one expected record per clock while the run is active
  always @(negedge clk) begin
    if (running) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL underflow got=%b want=<queued record>", actual);
      end else begin
        check_output("trace", actual, exp_q.pop_front(), tag_q.pop_front());
      end
      compared++;
      if (mem_read && mem_write) begin
        mismatched++;
        $display("[TB] FAIL rw_exclusive got mem_read=1 mem_write=1 want not both");
      end
    end
  end

  task automatic run_instr(input logic [3:0] op, ext, input bit cond,
                           input int fetch_wait, mem_wait, halt_cycles,
                           input bit noise, reset_in_mem);
    int  k;
    bit  fh;
    bit  hmid;
    bit  last;
    k  = classify(op, ext);
    fh = (halt_cycles > 0);
    instr_no++;
    for (int i = 0; i < fetch_wait; i++)
      apply_stimulus(0, 0, noise & $urandom_range(0, 1), $urandom_range(0, 1), op, ext,
                     mk(3'd0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply_stimulus(0, 1, noise & $urandom_range(0, 1), $urandom_range(0, 1), op, ext,
                   mk(3'd0, 0, 1, 0, 1, 1, 0, 0, 0));
    apply_stimulus(0, noise ? 1'($urandom_range(0, 1)) : 1'b1, noise & $urandom_range(0, 1),
                   $urandom_range(0, 1), op, ext, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0));
    hmid = fh ? 1'b1 : (noise & 1'($urandom_range(0, 1)));
    last = (k == K_BRANCH || k == K_NOP);
    apply_stimulus(0, noise ? 1'($urandom_range(0, 1)) : 1'b1, last ? fh : hmid, cond, op, ext,
                   mk(3'd2, 0, 0, 0, 0, 0, (k == K_BRANCH) && cond, 0, 0));
    if (k == K_LOAD || k == K_STOR) begin
      for (int i = 0; i < mem_wait; i++)
        apply_stimulus(0, 0, hmid, $urandom_range(0, 1), op, ext,
                       mk(3'd3, 0, k == K_LOAD, k == K_STOR, 0, 0, 0, 0, 0));
      if (reset_in_mem) begin
        apply_stimulus(1, 0, 0, 0, op, ext, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        return;
      end
      apply_stimulus(0, 1, (k == K_STOR) ? fh : hmid, $urandom_range(0, 1), op, ext,
                     mk(3'd3, 0, k == K_LOAD, k == K_STOR, 0, 0, 0, 0, 0));
    end
    if (k == K_ALU || k == K_WB || k == K_LOAD || k == K_JAL)
      apply_stimulus(0, noise ? 1'($urandom_range(0, 1)) : 1'b1, fh, $urandom_range(0, 1), op, ext,
                     mk(3'd4, 0, 0, 0, 0, 0, k == K_JAL, 1, k == K_ALU));
    for (int i = 0; i < halt_cycles; i++)
      apply_stimulus(0, $urandom_range(0, 1), 1, $urandom_range(0, 1), op, ext,
                     mk(3'd5, 1, 0, 0, 0, 0, 0, 0, 0));
    if (fh)
      apply_stimulus(0, $urandom_range(0, 1), 0, $urandom_range(0, 1), op, ext,
                     mk(3'd5, 1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // An out-of-range state must show no outputs and recover to FETCH
  task automatic force_illegal_state();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    mem_ready = 1'b0;
    halt_req  = 1'b0;
    force dut.state_q = state_e'(3'd7);
    exp_q.push_back(mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 0));
    tag_q.push_back(instr_no);
    @(negedge clk);
    #1;
    release dut.state_q;
  endtask

  initial begin
    logic [3:0] rop, rext;
    int         pick;
    running = 1'b1;
    $display("[TB] start");
    apply_stimulus(1, 0, 0, 0, 4'b0000, 4'b0000, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply_stimulus(1, 1, 1, 1, 4'b0000, 4'b0000, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));

    run_instr(4'b0000, 4'b0101, 0, 0, 0, 0, 0, 0);  // R-type
    run_instr(4'b0100, 4'b0000, 0, 0, 3, 0, 0, 0);  // LOAD, 3 wait cycles
    run_instr(4'b0100, 4'b1100, 1, 0, 0, 0, 0, 0);  // JCOND taken
    run_instr(4'b0100, 4'b1100, 0, 0, 0, 0, 0, 0);  // JCOND not taken
    run_instr(4'b0100, 4'b0100, 0, 1, 1, 2, 0, 0);  // STOR then HALT
    run_instr(4'b0100, 4'b0000, 0, 0, 1, 0, 0, 1);  // LOAD reset mid-MEM
    run_instr(4'b0000, 4'b0011, 0, 1, 0, 0, 0, 0);
    force_illegal_state();
    run_instr(4'b1100, 4'b0000, 1, 0, 0, 0, 0, 0);  // bcond
    run_instr(4'b0100, 4'b1000, 0, 0, 0, 0, 0, 0);  // JAL
    run_instr(4'b1111, 4'b0000, 0, 0, 0, 1, 0, 0);  // lui then HALT
    run_instr(4'b1000, 4'b0010, 0, 2, 0, 0, 0, 0);  // shift
    run_instr(4'b0011, 4'b0000, 0, 0, 0, 0, 0, 0);  // immediate
    run_instr(4'b0100, 4'b0001, 0, 0, 0, 1, 0, 0);  // special NOP then HALT

    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 4);
      rop  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) rop = 4'b0100;
      rext = (pick < 4) ? 4'(pick * 4) : 4'($urandom_range(0, 15));
      run_instr(rop, rext, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                $urandom_range(0, 2), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0,
                1, 0);
    end

    @(negedge clk);
    #1;
    running = 1'b0;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL leftover got=%0d queued records want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
